// File: rtl/mm_pkg.sv
// Shared definitions for the Montgomery final-subtraction block.
// Provides word/operand size defaults, the controller state encoding and
// a helper for sizing the word counter.
package mm_pkg;

   localparam int RADIX_DEF = 32;
   localparam int WORDS_DEF = 12;
   localparam int CNT_W     = $clog2(WORDS_DEF);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      SELECT  = 2'd2,
      DONE    = 2'd3
   } mm_state_t;

   // Counter width for an arbitrary word count; never narrower than one bit.
   function automatic int cnt_width(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/mm_word_sub.sv
// One RADIX-bit subtract stage: {borrow_out, diff} = a - b - borrow_in.
module mm_word_sub #(
   parameter int RADIX = 32
) (
   input  logic [RADIX-1:0] a,
   input  logic [RADIX-1:0] b,
   input  logic             borrow_in,
   output logic [RADIX-1:0] diff,
   output logic             borrow_out
);

   logic [RADIX:0] wide;

   // Extending by one bit makes the top bit of the wrapped result the borrow.
   always_comb begin
      wide       = {1'b0, a} - {1'b0, b} - {{RADIX{1'b0}}, borrow_in};
      diff       = wide[RADIX-1:0];
      borrow_out = wide[RADIX];
   end

endmodule

// File: rtl/mm_final_sub.sv
// Final conditional subtraction for the Montgomery multiplier.
// Collects the result words LSW-first, computes T - p word-serially while
// they arrive, then selects T or T - p and presents it under valid/ack.
// Optional build macro: MM_FINAL_SUB_ZEROIZE_EN clears the result buffers
// after the consumer acknowledges and after an early-last abort.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start
//   COLLECT | accepting result words, running the subtraction
//   SELECT  | one cycle: choose T or T - p into res
//   DONE    | res_valid high, holding res until res_ack
module mm_final_sub
   import mm_pkg::*;
#(
   parameter int RADIX = RADIX_DEF,
   parameter int WORDS = WORDS_DEF
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [RADIX*WORDS-1:0] prime_in,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [RADIX-1:0]       in_word,
   input  logic                   in_last,
   input  logic                   in_carry,
   output logic                   res_valid,
   input  logic                   res_ack,
   output logic [RADIX*WORDS-1:0] res,
   output logic                   err,
   output logic                   busy
);

   localparam int CW = cnt_width(WORDS);
   localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

   mm_state_t state, state_nx;

   logic [CW-1:0]                counter;
   logic                         borrow;
   logic                         carry_reg;
   logic [WORDS-1:0][RADIX-1:0]  t_buf;
   logic [WORDS-1:0][RADIX-1:0]  d_buf;
   logic [WORDS-1:0][RADIX-1:0]  p_words;

   logic                         hs;
   logic                         at_last;
   logic [RADIX-1:0]             diff_w;
   logic                         borrow_nx;
   logic                         sel_sub;
   logic [RADIX*WORDS-1:0]       res_sel;

   assign p_words = prime_in;
   assign hs      = in_valid & in_ready;
   assign at_last = (counter == LAST_IDX);

   mm_word_sub #(.RADIX(RADIX)) u_word_sub (
      .a          (in_word),
      .b          (p_words[counter]),
      .borrow_in  (borrow),
      .diff       (diff_w),
      .borrow_out (borrow_nx)
   );

   // A final borrow means T < p, unless the top carry says T exceeds the word range.
   assign sel_sub = carry_reg | ~borrow;
   assign res_sel = sel_sub ? d_buf : t_buf;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode; the counter, not in_last, decides which word is final.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (start) state_nx = COLLECT;
         end
         COLLECT: begin
            if (hs) begin
               if (at_last)      state_nx = SELECT;
               else if (in_last) state_nx = IDLE;
            end
         end
         SELECT: begin
            state_nx = DONE;
         end
         DONE: begin
            if (res_ack) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Status outputs decoded straight from the state.
   always_comb begin
      in_ready  = (state == COLLECT);
      res_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   // Datapath: word capture, serial borrow chain, result select, sticky error.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         counter   <= '0;
         borrow    <= 1'b0;
         carry_reg <= 1'b0;
         t_buf     <= '0;
         d_buf     <= '0;
         res       <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  counter <= '0;
                  borrow  <= 1'b0;
                  err     <= 1'b0;
               end
            end
            COLLECT: begin
               if (hs) begin
                  t_buf[counter] <= in_word;
                  d_buf[counter] <= diff_w;
                  borrow         <= borrow_nx;
                  counter        <= counter + CW'(1);
                  if (at_last) begin
                     carry_reg <= in_carry;
                     if (!in_last) err <= 1'b1;
                  end else if (in_last) begin
                     err <= 1'b1;
`ifdef MM_FINAL_SUB_ZEROIZE_EN
                     t_buf <= '0;
                     d_buf <= '0;
`endif
                  end
               end
            end
            SELECT: begin
               res <= res_sel;
            end
            DONE: begin
`ifdef MM_FINAL_SUB_ZEROIZE_EN
               if (res_ack) begin
                  t_buf     <= '0;
                  d_buf     <= '0;
                  res       <= '0;
                  carry_reg <= 1'b0;
               end
`endif
            end
            default: ;
         endcase
      end
   end

endmodule
